// File: rtl/signal_player_pkg.sv
// Shared types and constants for the signal ROM playback sequencer.
package signal_player_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Highest address of a ROM with the given address width.
  function automatic int unsigned rom_last_addr(input int unsigned addr_width);
    return (32'd1 << addr_width) - 32'd1;
  endfunction

endpackage

// File: rtl/player_period_cnt.sv
// Sample-period counter: loads the hold count, decrements it, flags zero.
module player_period_cnt #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 dec,
  input  logic [DIV_WIDTH-1:0] load_val,
  output logic [DIV_WIDTH-1:0] cnt,
  output logic                 zero
);

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - DIV_WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/signal_rom_player.sv
// Playback sequencer walking a sync-read ROM from address 0 at a programmable sample period.
// Optional feature: define SIGNAL_PLAYER_END_ADDR_EN to add end_addr_i (programmable last address).
module signal_rom_player
  import signal_player_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 1,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  loop_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
`ifdef SIGNAL_PLAYER_END_ADDR_EN
  input  logic [ADDR_WIDTH-1:0] end_addr_i,
`endif
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] sample_o,
  output logic                  sample_valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   sample_d;
  logic                    valid_d;
  logic                    done_d;
  logic                    start_accept;
  logic                    cnt_load;
  logic                    cnt_dec;
  logic                    cnt_zero;
  logic [DIV_WIDTH-1:0]    cnt;
  logic [ADDR_WIDTH-1:0]   last_addr;

`ifdef SIGNAL_PLAYER_END_ADDR_EN
  logic [ADDR_WIDTH-1:0] last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
    end else if (start_accept) begin
      last_q <= end_addr_i;
    end
  end

  assign last_addr = last_q;
`else
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(rom_last_addr(ADDR_WIDTH));

  assign last_addr = LAST_ADDR;
`endif

  player_period_cnt #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_period_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (div_i),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = rom_addr_o;
    sample_d     = sample_o;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    start_accept = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;

    // Abort outranks everything, including a simultaneous start.
    if (state_q != IDLE && stop_i) begin
      state_d  = IDLE;
      addr_d   = '0;
      sample_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i && !stop_i) begin
            start_accept = 1'b1;
            addr_d       = '0;
            state_d      = FETCH;
          end
        end
        FETCH: begin
          state_d = CAPTURE;
        end
        CAPTURE: begin
          sample_d = rom_data_i;
          valid_d  = 1'b1;
          cnt_load = 1'b1;
          state_d  = HOLD;
        end
        HOLD: begin
          if (!cnt_zero) begin
            cnt_dec = 1'b1;
          end else if (rom_addr_o != last_addr) begin
            addr_d  = rom_addr_o + ADDR_WIDTH'(1);
            state_d = FETCH;
          end else if (loop_i) begin
            addr_d  = '0;
            state_d = FETCH;
          end else begin
            done_d   = 1'b1;
            sample_d = '0;
            addr_d   = '0;
            state_d  = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_o     <= '0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      rom_addr_o     <= addr_d;
      sample_o       <= sample_d;
      sample_valid_o <= valid_d;
      done_o         <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_signal_rom_player.sv
// Directed self-checking bench for signal_rom_player against a 256x1 sync ROM holding 0xA5 bitwise.
module tb_signal_rom_player;

  localparam int AW = 8;
  localparam int DW = 1;
  localparam int VW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          loop_i = 1'b0;
  logic [VW-1:0] div_i = '0;
  logic [AW-1:0] rom_addr_o;
  logic [DW-1:0] rom_data_i;
  logic [DW-1:0] sample_o;
  logic          sample_valid_o;
  logic          busy_o;
  logic          done_o;
`ifdef SIGNAL_PLAYER_END_ADDR_EN
  logic [AW-1:0] end_addr_i = 8'hFF;
`endif

  logic [7:0] pat = 8'hA5;
  int n_checks = 0;
  int n_fails  = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data_i <= pat[rom_addr_o[2:0]];

  signal_rom_player #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DIV_WIDTH  (VW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .loop_i         (loop_i),
    .div_i          (div_i),
`ifdef SIGNAL_PLAYER_END_ADDR_EN
    .end_addr_i     (end_addr_i),
`endif
    .rom_addr_o     (rom_addr_o),
    .rom_data_i     (rom_data_i),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (done_o) done_cnt++;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      cyc++;
      if (sample_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Expects n samples at the given period starting from first_addr; first_gap is the
  // distance to the first pulse from the current negedge.
  task automatic run_samples(input int n, input int period, input int first_gap, input int first_addr);
    int  cyc;
    bit  ok;
    int  a;
    for (int k = 0; k < n; k++) begin
      wait_valid(period + 4, cyc, ok);
      check("valid_timeout", 32'(ok), 32'd1);
      if (!ok) return;
      a = (first_addr + k) % 256;
      check("gap", 32'(cyc), 32'((k == 0) ? first_gap : period));
      check("addr", 32'(rom_addr_o), 32'(a));
      check("sample", 32'(sample_o), 32'(pat[a % 8]));
    end
  endtask

  task automatic wait_done(input int exp_gap);
    int gap;
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      gap++;
      if (done_o || sample_valid_o) break;
    end
    check("done_gap", 32'(gap), 32'(exp_gap));
    check("done_pulse", 32'(done_o), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_addr", 32'(rom_addr_o), 32'd0);
    check("rst_sample", 32'(sample_o), 32'd0);
    check("rst_valid", 32'(sample_valid_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    rst = 1'b0;
    tick();

    // Full non-loop playback, period 5
    div_i  = 16'd2;
    loop_i = 1'b0;
    pulse_start();
    check("busy_after_start", 32'(busy_o), 32'd1);
    run_samples(256, 5, 2, 0);
    wait_done(3);
    check("end_busy", 32'(busy_o), 32'd0);
    check("end_sample", 32'(sample_o), 32'd0);
    check("end_addr", 32'(rom_addr_o), 32'd0);
    tick();
    check("done_one_cycle", 32'(done_o), 32'd0);
    check("done_count_1", 32'(done_cnt), 32'd1);

    // Looping playback, period 3, across the wrap
    div_i  = 16'd0;
    loop_i = 1'b1;
    pulse_start();
    run_samples(260, 3, 2, 0);
    check("loop_busy", 32'(busy_o), 32'd1);
    pulse_stop();
    check("loop_stop_busy", 32'(busy_o), 32'd0);
    check("loop_stop_sample", 32'(sample_o), 32'd0);
    check("loop_no_done", 32'(done_cnt), 32'd1);

    // Stop at address 10
    div_i  = 16'd4;
    loop_i = 1'b0;
    pulse_start();
    run_samples(11, 7, 2, 0);
    check("pre_stop_sample", 32'(sample_o), 32'd1);
    pulse_stop();
    check("stop_busy", 32'(busy_o), 32'd0);
    check("stop_sample", 32'(sample_o), 32'd0);
    check("stop_addr", 32'(rom_addr_o), 32'd0);
    check("stop_done", 32'(done_o), 32'd0);
    repeat (3) tick();
    check("stop_no_done", 32'(done_cnt), 32'd1);

    // Replay after stop; start during HOLD is ignored
    pulse_start();
    run_samples(1, 7, 2, 0);
    pulse_start();
    run_samples(3, 7, 6, 1);
    pulse_stop();
    check("hold_start_stop_busy", 32'(busy_o), 32'd0);

    // Simultaneous start and stop in IDLE
    start_i = 1'b1;
    stop_i  = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
    check("collide_busy0", 32'(busy_o), 32'd0);
    tick();
    check("collide_busy1", 32'(busy_o), 32'd0);
    check("collide_addr", 32'(rom_addr_o), 32'd0);

    // Asynchronous reset between edges during HOLD
    pulse_start();
    run_samples(3, 7, 2, 0);
    tick();
    check("pre_rst_sample", 32'(sample_o), 32'd1);
    check("pre_rst_addr", 32'(rom_addr_o), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_addr", 32'(rom_addr_o), 32'd0);
    check("arst_sample", 32'(sample_o), 32'd0);
    check("arst_valid", 32'(sample_valid_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("arst_no_done", 32'(done_cnt), 32'd1);
    div_i = 16'd0;
    pulse_start();
    run_samples(3, 3, 2, 0);
    pulse_stop();

`ifdef SIGNAL_PLAYER_END_ADDR_EN
    // Programmable last address
    div_i      = 16'd1;
    end_addr_i = 8'd3;
    pulse_start();
    end_addr_i = 8'hFF;
    run_samples(4, 4, 2, 0);
    wait_done(2);
    check("end3_busy", 32'(busy_o), 32'd0);
    end_addr_i = 8'd0;
    pulse_start();
    end_addr_i = 8'hFF;
    run_samples(1, 4, 2, 0);
    wait_done(2);
    check("end0_done_count", 32'(done_cnt), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
